// File: rtl/pocket_frame_trig.sv
// Purpose: frame tracker feeding the Pocket sim dump stage (frame count, strobe, dump window, finish, heartbeat, vsync watchdog).
// Latency: VGA_VS first sampled low at edge k -> frame_stb/frame_cnt update after edge k+2; all outputs registered.
// Backpressure: none; free-running observer, every frame boundary is reported unconditionally.
//
// Ports:
//   clk, rst      - single clock, synchronous active-high reset (dominates everything)
//   VGA_VS        - active-low vertical sync, asynchronous to clk
//   frame_cnt     - frames since reset (wraps), frame_stb - one-cycle pulse per frame
//   dump_en       - dump window, finish - sticky end-of-run request
//   led           - toggles every LED_DIV frames, vs_lost - no frame for 2^TOUT_W-1 clocks
module pocket_frame_trig #(
    parameter int unsigned DUMP_START = 0,
    parameter int unsigned DUMP_LEN   = 0,
    parameter int unsigned MAX_FRAMES = 0,
    parameter int unsigned LED_DIV    = 32,
    parameter int unsigned TOUT_W     = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        VGA_VS,
    output logic [31:0] frame_cnt,
    output logic        frame_stb,
    output logic        dump_en,
    output logic        finish,
    output logic        led,
    output logic        vs_lost
);

    localparam logic [31:0] LP_START   = DUMP_START;
    localparam logic [31:0] LP_LEN     = DUMP_LEN;
    localparam logic [31:0] LP_MAX     = MAX_FRAMES;
    localparam logic [15:0] LP_DIV_TOP = 16'(LED_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // synchronizer and edge detect
    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic w_fall;

    // frame counter
    logic [31:0] r_frame_cnt;
    logic        r_frame_stb;

    // dump window
    state_t      r_state;
    logic [31:0] r_wcnt;
    logic [31:0] w_wcnt_nxt;
    logic        r_dump_en;

    // finish / heartbeat / watchdog
    logic              r_finish;
    logic [15:0]       r_div;
    logic              r_led;
    logic [TOUT_W-1:0] r_wd;
    logic [TOUT_W-1:0] w_wd_nxt;
    logic              r_vs_lost;

    // Three flops: two for metastability, the third holds the previous
    // synchronized level so a high->low transition can be seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= VGA_VS;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Resetting the chain to 0 means a high must be observed before the
    // first fall, so VGA_VS held low across reset release is not a frame.
    assign w_fall = r_s3 & ~r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= 32'd0;
            r_frame_stb <= 1'b0;
        end else begin
            r_frame_stb <= w_fall;
            if (w_fall) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
        end
    end

    // The window counter includes the strobe arriving this cycle, so the
    // window closes one edge after frame_cnt reaches DUMP_START+DUMP_LEN,
    // matching the one-edge lag with which it opened.
    assign w_wcnt_nxt = r_wcnt + {31'd0, r_frame_stb};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_wcnt    <= 32'd0;
            r_dump_en <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_frame_cnt == LP_START) begin
                        r_state   <= ST_DUMP;
                        r_wcnt    <= 32'd0;
                        r_dump_en <= 1'b1;
                    end
                end
                ST_DUMP: begin
                    r_wcnt <= w_wcnt_nxt;
                    if ((LP_LEN != 32'd0) && (w_wcnt_nxt == LP_LEN)) begin
                        r_state   <= ST_DONE;
                        r_dump_en <= 1'b0;
                    end
                end
                ST_DONE: begin
                    // sticky: a frame_cnt wrap must not reopen the window
                    r_dump_en <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_dump_en <= 1'b0;
                end
            endcase
        end
    end

    // finish is sticky, so a later wrap past MAX_FRAMES changes nothing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_finish <= 1'b0;
        end else if ((LP_MAX != 32'd0) && (r_frame_cnt == LP_MAX)) begin
            r_finish <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= 16'd0;
            r_led <= 1'b0;
        end else if (r_frame_stb) begin
            if (r_div == LP_DIV_TOP) begin
                r_div <= 16'd0;
                r_led <= ~r_led;
            end else begin
                r_div <= r_div + 16'd1;
            end
        end
    end

    // Watchdog: clear beats saturation when both happen together.
    always_comb begin
        w_wd_nxt = r_wd;
        if (r_frame_stb) begin
            w_wd_nxt = '0;
        end else if (~&r_wd) begin
            w_wd_nxt = r_wd + TOUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd      <= '0;
            r_vs_lost <= 1'b0;
        end else begin
            r_wd      <= w_wd_nxt;
            r_vs_lost <= &w_wd_nxt;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign frame_stb = r_frame_stb;
    assign dump_en   = r_dump_en;
    assign finish    = r_finish;
    assign led       = r_led;
    assign vs_lost   = r_vs_lost;

endmodule

// File: tb/tb_pocket_frame_trig.sv
// Purpose: self-checking bench for pocket_frame_trig, two parameter sets driven in parallel.
// Latency: expected outputs are queued one per clock edge and popped on the following falling edge.
// Backpressure: none; the monitor consumes one expectation per DUT per cycle.
module tb_pocket_frame_trig;

    typedef struct packed {
        logic [31:0] cnt;
        logic        stb;
        logic        dump;
        logic        fin;
        logic        led;
        logic        lost;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic VGA_VS;

    logic [31:0] a_cnt, b_cnt;
    logic a_stb, a_dump, a_fin, a_led, a_lost;
    logic b_stb, b_dump, b_fin, b_led, b_lost;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Set A: bounded window, finish enabled, led every 2 frames, short watchdog.
    pocket_frame_trig #(
        .DUMP_START(3), .DUMP_LEN(2), .MAX_FRAMES(4), .LED_DIV(2), .TOUT_W(8)
    ) u_a (
        .clk(clk), .rst(rst), .VGA_VS(VGA_VS),
        .frame_cnt(a_cnt), .frame_stb(a_stb), .dump_en(a_dump),
        .finish(a_fin), .led(a_led), .vs_lost(a_lost)
    );

    // Set B: window open from reset and never closing, no finish, led every frame.
    pocket_frame_trig #(
        .DUMP_START(0), .DUMP_LEN(0), .MAX_FRAMES(0), .LED_DIV(1), .TOUT_W(10)
    ) u_b (
        .clk(clk), .rst(rst), .VGA_VS(VGA_VS),
        .frame_cnt(b_cnt), .frame_stb(b_stb), .dump_en(b_dump),
        .finish(b_fin), .led(b_led), .vs_lost(b_lost)
    );

    // ---------------- reference model ----------------
    int unsigned p_start [2];
    int unsigned p_len   [2];
    int unsigned p_max   [2];
    int unsigned p_div   [2];
    int unsigned p_tout  [2];

    logic [31:0] m_frames [2];   // frames counted since reset
    logic [31:0] m_base   [2];   // frame count when the window opened
    logic        m_open   [2];
    logic        m_closed [2];
    logic        m_fin    [2];
    logic        m_pstb   [2];   // strobe was shown during the previous cycle
    int          m_quiet0 [2];   // edge from which the watchdog restarts counting

    logic        vs_hist [$];    // VGA_VS samples of the last three edges, oldest first
    int          edge_n = 0;

    obs_t exp_qa [$];
    obs_t exp_qb [$];

    task automatic model_cfg(input int c, input logic r, input logic fall, output obs_t o);
        logic [31:0] fp;
        o = '0;
        if (r) begin
            m_frames[c] = 32'd0;
            m_open[c]   = 1'b0;
            m_closed[c] = 1'b0;
            m_fin[c]    = 1'b0;
            m_pstb[c]   = 1'b0;
            m_quiet0[c] = edge_n;
        end else begin
            fp = m_frames[c];
            // window: opens the edge after frame count equals START, closes
            // the edge after LEN further frames have been counted
            if (!m_open[c]) begin
                if (fp == p_start[c]) begin
                    m_open[c] = 1'b1;
                    m_base[c] = fp;
                end
            end else if (!m_closed[c] && p_len[c] != 0 && (fp - m_base[c]) == p_len[c]) begin
                m_closed[c] = 1'b1;
            end
            if (p_max[c] != 0 && fp == p_max[c]) m_fin[c] = 1'b1;
            if (m_pstb[c]) m_quiet0[c] = edge_n;
            o.dump = m_open[c] && !m_closed[c];
            o.fin  = m_fin[c];
            o.led  = ((fp / p_div[c]) % 2) == 1;
            o.lost = (edge_n - m_quiet0[c]) >= ((1 << p_tout[c]) - 1);
            o.stb  = fall;
            if (fall) m_frames[c] = m_frames[c] + 32'd1;
            m_pstb[c] = fall;
            o.cnt = m_frames[c];
        end
    endtask

    task automatic step(input logic r, input logic v);
        obs_t ea, eb;
        logic fall;
        rst    = r;
        VGA_VS = v;
        @(posedge clk);
        #1;
        edge_n++;
        if (r) begin
            vs_hist = '{1'b0, 1'b0, 1'b0};
            fall = 1'b0;
        end else begin
            // frame seen two edges after VGA_VS is first sampled low
            fall = vs_hist[0] && !vs_hist[1];
            vs_hist.push_back(v);
            void'(vs_hist.pop_front());
        end
        model_cfg(0, r, fall, ea);
        model_cfg(1, r, fall, eb);
        exp_qa.push_back(ea);
        exp_qb.push_back(eb);
    endtask

    task automatic frame(input int hi, input int lo);
        repeat (hi) step(1'b0, 1'b1);
        repeat (lo) step(1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic cmp_obs(input int id, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL obs_dut%0d edge=%0d got cnt=%0d stb=%b dump=%b fin=%b led=%b lost=%b want cnt=%0d stb=%b dump=%b fin=%b led=%b lost=%b",
                     id, edge_n, got.cnt, got.stb, got.dump, got.fin, got.led, got.lost,
                     want.cnt, want.stb, want.dump, want.fin, want.led, want.lost);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        obs_t ea, eb;
        if (exp_qa.size() > 0 && exp_qb.size() > 0) begin
            ea = exp_qa.pop_front();
            eb = exp_qb.pop_front();
            cmp_obs(0, {a_cnt, a_stb, a_dump, a_fin, a_led, a_lost}, ea);
            cmp_obs(1, {b_cnt, b_stb, b_dump, b_fin, b_led, b_lost}, eb);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        p_start = '{3, 0};
        p_len   = '{2, 0};
        p_max   = '{4, 0};
        p_div   = '{2, 1};
        p_tout  = '{8, 10};
        rst     = 1'b1;
        VGA_VS  = 1'b0;

        // reset, then VGA_VS held low: no frame may be reported
        repeat (3) step(1'b1, 1'b0);
        repeat (100) step(1'b0, 1'b0);
        chk("idle_cnt_a", a_cnt, 32'd0);
        chk("idle_cnt_b", b_cnt, 32'd0);

        // slow square wave, 10 frames; watchdog of set A fires in each half
        repeat (10) frame(500, 500);
        chk("square_cnt_a", a_cnt, 32'd10);
        chk("square_fin_a", {31'd0, a_fin}, 32'd1);
        chk("square_dump_a", {31'd0, a_dump}, 32'd0);

        // random frames with occasional long gaps
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0)
                frame($urandom_range(1, 30), $urandom_range(260, 1100));
            else
                frame($urandom_range(1, 30), $urandom_range(1, 30));
        end

        // per-cycle random level, including single-cycle glitches
        for (int i = 0; i < 300; i++) step(1'b0, 1'($urandom_range(0, 1)));

        // reset, count up to frame 7 with the window open, reset again
        repeat (2) step(1'b1, 1'($urandom_range(0, 1)));
        guard = 0;
        while (m_frames[1] != 32'd7 && guard < 50) begin
            frame($urandom_range(1, 12), $urandom_range(3, 12));
            guard++;
        end
        chk("pre_rst_cnt_b", b_cnt, 32'd7);
        chk("pre_rst_dump_b", {31'd0, b_dump}, 32'd1);
        step(1'b1, 1'b1);
        chk("rst_all_b", {b_cnt, b_stb, b_dump, b_fin, b_led, b_lost}, 37'd0);
        step(1'b0, 1'b1);
        chk("reopen_dump_b", {31'd0, b_dump}, 32'd1);

        // a few frames, then a long silence to fire set B's watchdog, then recover
        for (int i = 0; i < 8; i++) frame($urandom_range(1, 20), $urandom_range(3, 20));
        repeat (1100) step(1'b0, 1'b1);
        chk("silence_lost_b", {31'd0, b_lost}, 32'd1);
        frame(1, 10);
        chk("recover_lost_b", {31'd0, b_lost}, 32'd0);

        // drain the scoreboard
        @(negedge clk);
        #1;
        chk("queue_drained", exp_qa.size() + exp_qb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
